sram_arbiter: RTL and testbench
===============================

// Module: sram_arbiter
// PURPOSE
//  Downstream memory stage of the CPU core: consumes the data-port request (address, 2-bit mem control,
//  store data) and the instruction-fetch request, and serialises both onto one asynchronous SRAM.
//  Returns load/fetch data and a stall that freezes the pipeline until the combined access completes.
//  Data port (A) has priority over fetch port (B) within each access window.
// PARAMETERS
//  ADDR_W   16  SRAM/CPU address width
//  DATA_W   16  SRAM data width
//  ACC_CYC  2   clocks per SRAM access, legal 1..15
// PORTS
//  clk          in     1        system clock, rising edge
//  rst          in     1        asynchronous reset, active-high
//  a_ctrl       in     2        data request: 00 none, 01 read, 10 write, 11 reserved (= none)
//  a_addr       in     ADDR_W   data address
//  a_wdata      in     DATA_W   store data
//  a_rdata      out    DATA_W   load data, registered
//  b_req        in     1        instruction fetch request
//  b_addr       in     ADDR_W   fetch address
//  b_rdata      out    DATA_W   fetched instruction, registered
//  stall        out    1        pipeline hold, combinational
//  sram_addr    out    ADDR_W   SRAM address
//  sram_data    inout  DATA_W   SRAM bidirectional data
//  sram_ce_n    out    1        chip enable, active-low
//  sram_oe_n    out    1        output enable, active-low
//  sram_we_n    out    1        write enable, active-low
//  conflict_cnt out    16       only with SRAM_ARB_STATS_EN
// BEHAVIOUR
//  Reset (async): state IDLE; a_rdata=b_rdata=0; sram_addr=0; ce_n=oe_n=we_n=1; sram_data=Z; stall=0.
//  FSM: IDLE -> SERVE_A | SERVE_B -> DONE -> IDLE.
//   IDLE: if a_ctrl in {01,10}: latch a_ctrl/a_addr/a_wdata/b_req/b_addr, go SERVE_A.
//         Else if b_req: latch b_addr, go SERVE_B. Else stay.
//   SERVE_A/SERVE_B: last exactly ACC_CYC cycles (counter cnt 0..ACC_CYC-1).
//   End of SERVE_A: go SERVE_B if latched b_req, else go DONE. End of SERVE_B: go DONE.
//   DONE: one cycle, stall=0, rdata stable; then IDLE.
//  stall = !rst && state!=DONE && (a_ctrl in {01,10} || b_req).
//   Inputs are held stable by the CPU while stall=1; the arbiter uses only the latched copies.
//  Read access: ce_n=0 and oe_n=0 for all ACC_CYC cycles; sram_addr = latched address.
//   Data is captured into a_rdata/b_rdata at the clock edge ending cnt=ACC_CYC-1.
//  Write access: ce_n=0, oe_n=1; sram_data driven with latched wdata for all ACC_CYC cycles.
//   ACC_CYC>=2: we_n=0 only for cnt 1..ACC_CYC-1. ACC_CYC=1: we_n=0 for the whole cycle.
//   All control outputs are registered or decoded from registered state (glitch-free we_n).
//  Outside SERVE_A/SERVE_B: ce_n=oe_n=we_n=1; sram_data=Z.
//  Latency (ACC_CYC=2): fetch only = 3 stall cycles; data + fetch = 5 stall cycles.
//  Unaffected rdata register keeps its old value (e.g. a_rdata unchanged on store or fetch-only).
//  Reset mid-access: we_n/oe_n/ce_n go high and bus goes Z asynchronously; the interrupted write is lost.
// CONFIGURATION
//  SRAM_ARB_STATS_EN defined: 16-bit conflict_cnt port.
//   Increments on every IDLE->SERVE_A transition where b_req=1; saturates at 16'hFFFF; reset 0.
//  SRAM_ARB_STATS_EN undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Package mem_arb_pkg: MEM_NONE=2'b00, MEM_READ=2'b01, MEM_WRITE=2'b10; FSM state encoding.
//  Sub-module sram_access_seq: one access.
//   Inputs: start, rw, addr, wdata. Outputs: done, rdata, sram pins. Contains cnt and we_n timing.
//  The arbiter FSM selects the port and drives start.
// TESTING (ACC_CYC=2, behavioural SRAM model)
//  1. rst held, a_ctrl=01, b_req=1 -> stall=0, ce_n/oe_n/we_n=1, sram_data=Z, rdata=0.
//  2. Fetch only, b_addr=0x0010, mem=0x4A21 -> stall=1 for 3 cycles; in DONE b_rdata=0x4A21.
//  3. Load a_addr=0x8000 (0x1234) + fetch 0x0011 (0xABCD) -> sram_addr 8000,8000,0011,0011;
//     stall=1 for 5 cycles; DONE: a_rdata=0x1234, b_rdata=0xABCD.
//  4. Store a_addr=0x8001, a_wdata=0x5555 + fetch -> we_n=0 only in cycle cnt=1 of SERVE_A;
//     bus=0x5555 then Z; a later load of 0x8001 returns 0x5555.
//  5. rst asserted during SERVE_A write at cnt=1 -> we_n=1 and bus Z before next edge; FSM in IDLE.
//  6. a_ctrl=11 with b_req=1 -> treated as fetch only. With SRAM_ARB_STATS_EN, two load+fetch pairs
//     -> conflict_cnt=2.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the SRAM arbiter: memory-control encodings and arbiter FSM states.
// Optional statistics are enabled with SRAM_ARB_STATS_EN (see sram_arbiter.sv).
package mem_arb_pkg;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE_A = 2'd1,
    ST_SERVE_B = 2'd2,
    ST_DONE    = 2'd3
  } arb_state_e;

  // 2'b11 is reserved and behaves like MEM_NONE
  function automatic logic is_access(input logic [1:0] ctrl);
    return (ctrl == MEM_READ) || (ctrl == MEM_WRITE);
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// CPU-side bundle of the SRAM arbiter: data port (A), fetch port (B) and pipeline stall.
interface sram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic [1:0]        a_ctrl;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic [DATA_W-1:0] a_rdata;
  logic              b_req;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_rdata;
  logic              stall;

  modport master (
    output a_ctrl, a_addr, a_wdata, b_req, b_addr,
    input  a_rdata, b_rdata, stall
  );

  modport slave (
    input  a_ctrl, a_addr, a_wdata, b_req, b_addr,
    output a_rdata, b_rdata, stall
  );

endinterface

// File: rtl/sram_access_seq.sv
// One asynchronous-SRAM access of ACC_CYC clocks; every SRAM control pin and the
// bus drive enable come straight from flops so we_n cannot glitch.
module sram_access_seq #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int ACC_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam int               CNT_W    = 4;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_CYC - 1);
  localparam logic             ONE_CYC  = (ACC_CYC == 1);

  logic              busy_q, busy_d;
  logic              rw_q, rw_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              drive_q, drive_d;

  assign done      = busy_q && (cnt_q == LAST_CNT);
  // Read data is sampled by the arbiter at the edge that ends the last access cycle
  assign rdata     = sram_data;
  assign sram_addr = addr_q;
  assign sram_ce_n = ce_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;
  assign sram_data = drive_q ? wdata_q : {DATA_W{1'bz}};

  // Access counter and next-cycle pin levels
  always_comb begin
    busy_d  = busy_q;
    rw_d    = rw_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (start) begin
      busy_d  = 1'b1;
      rw_d    = rw;
      cnt_d   = 4'd0;
      addr_d  = addr;
      wdata_d = wdata;
    end else if (busy_q) begin
      if (cnt_q == LAST_CNT) begin
        busy_d = 1'b0;
        cnt_d  = 4'd0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end else begin
      busy_d = 1'b0;
    end
    ce_n_d  = !busy_d;
    oe_n_d  = !(busy_d && !rw_d);
    // First cycle of a multi-cycle write settles address/data before we_n falls
    we_n_d  = !(busy_d && rw_d && (ONE_CYC || (cnt_d != 4'd0)));
    drive_d = busy_d && rw_d;
  end

  // Sequencer state; reset releases the bus and deasserts all strobes at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= 1'b0;
      rw_q    <= 1'b0;
      cnt_q   <= 4'd0;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      drive_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      rw_q    <= rw_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      drive_q <= drive_d;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Serialises CPU data (A, priority) and fetch (B) requests onto one async SRAM.
// Define SRAM_ARB_STATS_EN to add the saturating conflict_cnt port.
module sram_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int ACC_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  sram_arbiter_if.slave     cpu,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [15:0]       conflict_cnt
`endif
);

  arb_state_e        state_q, state_d;
  logic              b_pend_q, b_pend_d;
  logic [ADDR_W-1:0] b_addr_q, b_addr_d;
  logic              a_read_q, a_read_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

  logic              seq_start_s;
  logic              seq_rw_s;
  logic [ADDR_W-1:0] seq_addr_s;
  logic [DATA_W-1:0] seq_wdata_s;
  logic              seq_done_s;
  logic [DATA_W-1:0] seq_rdata_s;

  sram_access_seq #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .ACC_CYC (ACC_CYC)
  ) u_seq (
    .clk       (clk),
    .rst       (rst),
    .start     (seq_start_s),
    .rw        (seq_rw_s),
    .addr      (seq_addr_s),
    .wdata     (seq_wdata_s),
    .done      (seq_done_s),
    .rdata     (seq_rdata_s),
    .sram_addr (sram_addr),
    .sram_data (sram_data),
    .sram_ce_n (sram_ce_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n)
  );

  // Inputs are held while stalled, so stall can be decoded from the live request
  assign cpu.stall   = !rst && (state_q != ST_DONE) && (is_access(cpu.a_ctrl) || cpu.b_req);
  assign cpu.a_rdata = a_rdata_q;
  assign cpu.b_rdata = b_rdata_q;

  // Port selection, access launch and read-data capture
  always_comb begin
    state_d     = state_q;
    b_pend_d    = b_pend_q;
    b_addr_d    = b_addr_q;
    a_read_d    = a_read_q;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    seq_start_s = 1'b0;
    seq_rw_s    = 1'b0;
    seq_addr_s  = b_addr_q;
    seq_wdata_s = cpu.a_wdata;
    case (state_q)
      ST_IDLE: begin
        if (is_access(cpu.a_ctrl)) begin
          state_d     = ST_SERVE_A;
          seq_start_s = 1'b1;
          seq_rw_s    = (cpu.a_ctrl == MEM_WRITE);
          seq_addr_s  = cpu.a_addr;
          a_read_d    = (cpu.a_ctrl == MEM_READ);
          b_pend_d    = cpu.b_req;
          b_addr_d    = cpu.b_addr;
        end else if (cpu.b_req) begin
          state_d     = ST_SERVE_B;
          seq_start_s = 1'b1;
          seq_addr_s  = cpu.b_addr;
          b_pend_d    = 1'b0;
          b_addr_d    = cpu.b_addr;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVE_A: begin
        if (seq_done_s) begin
          if (a_read_q) begin
            a_rdata_d = seq_rdata_s;
          end else begin
            a_rdata_d = a_rdata_q;
          end
          // Chain straight into the fetch so no idle cycle separates the two accesses
          if (b_pend_q) begin
            state_d     = ST_SERVE_B;
            seq_start_s = 1'b1;
            seq_addr_s  = b_addr_q;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_SERVE_A;
        end
      end
      ST_SERVE_B: begin
        if (seq_done_s) begin
          b_rdata_d = seq_rdata_s;
          state_d   = ST_DONE;
        end else begin
          state_d = ST_SERVE_B;
        end
      end
      ST_DONE: begin
        b_pend_d = 1'b0;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Arbiter state and registered read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      b_pend_q  <= 1'b0;
      b_addr_q  <= {ADDR_W{1'b0}};
      a_read_q  <= 1'b0;
      a_rdata_q <= {DATA_W{1'b0}};
      b_rdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q   <= state_d;
      b_pend_q  <= b_pend_d;
      b_addr_q  <= b_addr_d;
      a_read_q  <= a_read_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

`ifdef SRAM_ARB_STATS_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  // A conflict is a data access that makes a simultaneous fetch wait
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if ((state_q == ST_IDLE) && is_access(cpu.a_ctrl) && cpu.b_req &&
        (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end else begin
      conflict_cnt_d = conflict_cnt_q;
    end
  end

  // Conflict counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt_q <= 16'd0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter (ACC_CYC=2) with a behavioural async SRAM model.
// A probe driver puts a known pattern on the bus wherever the arbiter must be high-Z.
module tb_sram_arbiter;

  localparam logic [15:0] PROBE = 16'hC3C3;

  logic        clk;
  logic        rst;
  logic [15:0] sram_addr;
  wire  [15:0] sram_data;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
`ifdef SRAM_ARB_STATS_EN
  logic [15:0] conflict_cnt;
`endif

  logic        probe_en;
  logic [15:0] mem [0:65535];
  int          n_checks;
  int          n_pass;
  int          n_acc;
  int          cyc;
  logic [15:0] addr_log [0:7];
  logic        we_log   [0:7];
  logic [15:0] bus_log  [0:7];

  sram_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  sram_arbiter #(.ADDR_W(16), .DATA_W(16), .ACC_CYC(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu       (bus),
    .sram_addr (sram_addr),
    .sram_data (sram_data),
    .sram_ce_n (sram_ce_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n)
`ifdef SRAM_ARB_STATS_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign sram_data = probe_en ? PROBE :
                     ((!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'hzzzz);

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) mem[sram_addr] <= sram_data;
  end

  task automatic run_access(output int cycles);
    cycles = 0;
    n_acc  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!sram_ce_n && n_acc < 8) begin
        addr_log[n_acc] = sram_addr;
        we_log[n_acc]   = sram_we_n;
        bus_log[n_acc]  = sram_data;
        n_acc++;
      end
      if (bus.stall) cycles++;
      else break;
    end
  endtask

  task automatic idle_inputs();
    @(posedge clk);
    #1;
    bus.a_ctrl = 2'b00;
    bus.b_req  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; probe_en = 1'b1;
    bus.a_ctrl = 2'b01; bus.a_addr = 16'h8000; bus.a_wdata = 16'h0000;
    bus.b_req = 1'b1; bus.b_addr = 16'h0010;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", bus.stall); else n_pass++;
    n_checks++; if (sram_ce_n !== 1'b1) $display("FAIL reset_ce_n: got %b want 1", sram_ce_n); else n_pass++;
    n_checks++; if (sram_oe_n !== 1'b1) $display("FAIL reset_oe_n: got %b want 1", sram_oe_n); else n_pass++;
    n_checks++; if (sram_we_n !== 1'b1) $display("FAIL reset_we_n: got %b want 1", sram_we_n); else n_pass++;
    n_checks++; if (sram_data !== PROBE) $display("FAIL reset_bus_z: got %h want %h", sram_data, PROBE); else n_pass++;
    n_checks++; if (bus.a_rdata !== 16'h0000) $display("FAIL reset_a_rdata: got %h want 0000", bus.a_rdata); else n_pass++;
    n_checks++; if (bus.b_rdata !== 16'h0000) $display("FAIL reset_b_rdata: got %h want 0000", bus.b_rdata); else n_pass++;
    n_checks++; if (sram_addr !== 16'h0000) $display("FAIL reset_addr: got %h want 0000", sram_addr); else n_pass++;
`ifdef SRAM_ARB_STATS_EN
    n_checks++; if (conflict_cnt !== 16'd0) $display("FAIL reset_conflict: got %0d want 0", conflict_cnt); else n_pass++;
`endif
    bus.a_ctrl = 2'b00; bus.b_req = 1'b0; probe_en = 1'b0; rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fetch_only();
    bus.b_req = 1'b1; bus.b_addr = 16'h0010;
    run_access(cyc);
    n_checks++; if (cyc !== 3) $display("FAIL fetch_stall: got %0d want 3", cyc); else n_pass++;
    n_checks++; if (n_acc !== 2) $display("FAIL fetch_acc_cycles: got %0d want 2", n_acc); else n_pass++;
    n_checks++; if (addr_log[0] !== 16'h0010) $display("FAIL fetch_addr: got %h want 0010", addr_log[0]); else n_pass++;
    n_checks++; if (bus.b_rdata !== 16'h4A21) $display("FAIL fetch_b_rdata: got %h want 4a21", bus.b_rdata); else n_pass++;
    n_checks++; if (sram_ce_n !== 1'b1) $display("FAIL fetch_done_ce_n: got %b want 1", sram_ce_n); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_load_fetch();
    bus.a_ctrl = 2'b01; bus.a_addr = 16'h8000; bus.b_req = 1'b1; bus.b_addr = 16'h0011;
    run_access(cyc);
    n_checks++; if (cyc !== 5) $display("FAIL lf_stall: got %0d want 5", cyc); else n_pass++;
    n_checks++; if (n_acc !== 4) $display("FAIL lf_acc_cycles: got %0d want 4", n_acc); else n_pass++;
    n_checks++; if ({addr_log[0], addr_log[1], addr_log[2], addr_log[3]} !== 64'h8000_8000_0011_0011)
      $display("FAIL lf_addr_seq: got %h %h %h %h want 8000 8000 0011 0011",
               addr_log[0], addr_log[1], addr_log[2], addr_log[3]);
    else n_pass++;
    n_checks++; if (bus.a_rdata !== 16'h1234) $display("FAIL lf_a_rdata: got %h want 1234", bus.a_rdata); else n_pass++;
    n_checks++; if (bus.b_rdata !== 16'hABCD) $display("FAIL lf_b_rdata: got %h want abcd", bus.b_rdata); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_store_fetch();
    bus.a_ctrl = 2'b10; bus.a_addr = 16'h8001; bus.a_wdata = 16'h5555;
    bus.b_req = 1'b1; bus.b_addr = 16'h0012;
    run_access(cyc);
    n_checks++; if (cyc !== 5) $display("FAIL sf_stall: got %0d want 5", cyc); else n_pass++;
    n_checks++; if ({we_log[0], we_log[1], we_log[2], we_log[3]} !== 4'b1011)
      $display("FAIL sf_we_n_seq: got %b%b%b%b want 1011", we_log[0], we_log[1], we_log[2], we_log[3]);
    else n_pass++;
    n_checks++; if (bus_log[0] !== 16'h5555) $display("FAIL sf_bus_cnt0: got %h want 5555", bus_log[0]); else n_pass++;
    n_checks++; if (bus_log[1] !== 16'h5555) $display("FAIL sf_bus_cnt1: got %h want 5555", bus_log[1]); else n_pass++;
    n_checks++; if (bus_log[2] !== 16'h0F0F) $display("FAIL sf_bus_fetch: got %h want 0f0f", bus_log[2]); else n_pass++;
    n_checks++; if (addr_log[2] !== 16'h0012) $display("FAIL sf_fetch_addr: got %h want 0012", addr_log[2]); else n_pass++;
    n_checks++; if (bus.a_rdata !== 16'h1234) $display("FAIL sf_a_rdata_kept: got %h want 1234", bus.a_rdata); else n_pass++;
    n_checks++; if (bus.b_rdata !== 16'h0F0F) $display("FAIL sf_b_rdata: got %h want 0f0f", bus.b_rdata); else n_pass++;
    probe_en = 1'b1;
    #1;
    n_checks++; if (sram_data !== PROBE) $display("FAIL sf_done_bus_z: got %h want %h", sram_data, PROBE); else n_pass++;
    probe_en = 1'b0;
    idle_inputs();
    n_checks++; if (mem[16'h8001] !== 16'h5555) $display("FAIL sf_mem_written: got %h want 5555", mem[16'h8001]); else n_pass++;
    bus.a_ctrl = 2'b01; bus.a_addr = 16'h8001;
    run_access(cyc);
    n_checks++; if (cyc !== 3) $display("FAIL reload_stall: got %0d want 3", cyc); else n_pass++;
    n_checks++; if (bus.a_rdata !== 16'h5555) $display("FAIL reload_a_rdata: got %h want 5555", bus.a_rdata); else n_pass++;
    n_checks++; if (bus.b_rdata !== 16'h0F0F) $display("FAIL reload_b_rdata_kept: got %h want 0f0f", bus.b_rdata); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_reserved_ctrl();
    bus.a_ctrl = 2'b11; bus.a_addr = 16'h8000; bus.b_req = 1'b1; bus.b_addr = 16'h0013;
    run_access(cyc);
    n_checks++; if (cyc !== 3) $display("FAIL rsv_stall: got %0d want 3", cyc); else n_pass++;
    n_checks++; if (addr_log[0] !== 16'h0013) $display("FAIL rsv_addr: got %h want 0013", addr_log[0]); else n_pass++;
    n_checks++; if (bus.b_rdata !== 16'h2468) $display("FAIL rsv_b_rdata: got %h want 2468", bus.b_rdata); else n_pass++;
    n_checks++; if (bus.a_rdata !== 16'h5555) $display("FAIL rsv_a_rdata_kept: got %h want 5555", bus.a_rdata); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_reset_mid_write();
    bus.a_ctrl = 2'b10; bus.a_addr = 16'h8002; bus.a_wdata = 16'h7777; bus.b_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    n_checks++; if (sram_we_n !== 1'b0) $display("FAIL rmw_we_low: got %b want 0", sram_we_n); else n_pass++;
    n_checks++; if (sram_data !== 16'h7777) $display("FAIL rmw_bus_drv: got %h want 7777", sram_data); else n_pass++;
    rst = 1'b1; probe_en = 1'b1;
    #1;
    n_checks++; if (sram_we_n !== 1'b1) $display("FAIL rmw_we_n: got %b want 1", sram_we_n); else n_pass++;
    n_checks++; if (sram_ce_n !== 1'b1) $display("FAIL rmw_ce_n: got %b want 1", sram_ce_n); else n_pass++;
    n_checks++; if (sram_data !== PROBE) $display("FAIL rmw_bus_z: got %h want %h", sram_data, PROBE); else n_pass++;
    n_checks++; if (bus.stall !== 1'b0) $display("FAIL rmw_stall: got %b want 0", bus.stall); else n_pass++;
    bus.a_ctrl = 2'b00;
    @(negedge clk);
    rst = 1'b0; probe_en = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (mem[16'h8002] !== 16'h1111) $display("FAIL rmw_write_lost: got %h want 1111", mem[16'h8002]); else n_pass++;
    n_checks++; if (bus.a_rdata !== 16'h0000) $display("FAIL rmw_a_rdata: got %h want 0000", bus.a_rdata); else n_pass++;
    bus.b_req = 1'b1; bus.b_addr = 16'h0010;
    run_access(cyc);
    n_checks++; if (cyc !== 3) $display("FAIL rmw_idle_fetch_stall: got %0d want 3", cyc); else n_pass++;
    n_checks++; if (bus.b_rdata !== 16'h4A21) $display("FAIL rmw_idle_fetch_data: got %h want 4a21", bus.b_rdata); else n_pass++;
    idle_inputs();
  endtask

`ifdef SRAM_ARB_STATS_EN
  task automatic test_stats();
    for (int k = 0; k < 2; k++) begin
      bus.a_ctrl = 2'b01; bus.a_addr = 16'h8000; bus.b_req = 1'b1; bus.b_addr = 16'h0011;
      run_access(cyc);
      idle_inputs();
    end
    n_checks++; if (conflict_cnt !== 16'd2) $display("FAIL stats_conflicts: got %0d want 2", conflict_cnt); else n_pass++;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_pass   = 0;
    probe_en = 1'b0;
    mem[16'h0010] <= 16'h4A21;
    mem[16'h0011] <= 16'hABCD;
    mem[16'h0012] <= 16'h0F0F;
    mem[16'h0013] <= 16'h2468;
    mem[16'h8000] <= 16'h1234;
    mem[16'h8001] <= 16'h0000;
    mem[16'h8002] <= 16'h1111;
    test_reset();
    test_fetch_only();
    test_load_fetch();
    test_store_fetch();
    test_reserved_ctrl();
    test_reset_mid_write();
`ifdef SRAM_ARB_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
